dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the byte-addressed, big-endian 64-byte DataMemory
//  (combinational read, write on posedge clk). Requester 0 = CPU load/store path,
//  requester 1 = debug/DMA loader. Grants one word access at a time, round-robin, and
//  drives address/data_in/memRead/memWrite from registers. Rejects accesses that would
//  run past the top of memory. Returns read data through a registered response.
// PARAMETERS
//  ADDR_W    6                 memory byte-address width
//  DATA_W    32                word width (4 bytes)
//  MAX_ADDR  2**ADDR_W-4 (60)  highest legal word start address; above -> error
// PORTS
//  clk            in   1          clock, all state on posedge
//  rst            in   1          asynchronous, active-high reset
//  req_valid      in   2          per-requester request valid
//  req_we         in   2          per-requester 1=write, 0=read
//  req_addr       in   2*ADDR_W   per-requester byte address, [ADDR_W*i +: ADDR_W]
//  req_wdata      in   2*DATA_W   per-requester write data, [DATA_W*i +: DATA_W]
//  req_ready      out  2          one-hot grant; handshake = valid & ready
//  resp_valid     out  2          one-hot, 1-cycle pulse to the owner of the completed access
//  resp_rdata     out  DATA_W     read data (0 for writes and errors); valid with resp_valid
//  resp_err       out  1          address > MAX_ADDR; valid with resp_valid
//  mem_address    out  ADDR_W     to DataMemory address
//  mem_data_in    out  DATA_W     to DataMemory data_in
//  memRead        out  1          to DataMemory memRead
//  memWrite       out  1          to DataMemory memWrite
//  mem_data_out   in   DATA_W     from DataMemory data_out
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_rdata=0,
//   resp_err=0, mem_address=0, mem_data_in=0, memRead=0, memWrite=0.
//  FSM IDLE -> EXEC -> RESP -> IDLE. One transaction per 3 cycles; no overlap.
//  IDLE: req_ready is combinational from req_valid and rr_ptr:
//   only one valid -> that one ready; both valid -> requester rr_ptr ready; none -> 0.
//   On handshake latch owner, we, addr, wdata; rr_ptr <= ~owner; go EXEC.
//   rr_ptr changes only on a grant. A lone requester may win every slot.
//  EXEC (cycle T+1): mem_address/mem_data_in come from the latched request.
//   Legal addr (<=MAX_ADDR): memRead=~we, memWrite=we. The write commits at the edge ending EXEC.
//   Read: mem_data_out is sampled into resp_rdata at that same edge.
//   Illegal addr: memRead=memWrite=0, resp_err set, resp_rdata=0. Go RESP.
//  RESP (cycle T+2): resp_valid[owner]=1 for exactly one cycle. memRead=memWrite=0,
//   req_ready=0. Go IDLE. The next grant is possible in T+3.
//  memRead/memWrite are high only in EXEC and never high together.
//  resp_rdata/resp_err hold their value until the next EXEC completes.
//  Unaligned legal addresses (e.g. 5) are allowed: memory handles byte order.
//  Address arithmetic is unsigned ADDR_W bits. Compare addr > MAX_ADDR; no wrap-around access ever issued.
//  Dropping req_valid before handshake is legal and leaves no effect.
//   Request fields are sampled only at the handshake.
//  rst during EXEC: memWrite drops asynchronously, the write is aborted,
//   no resp_valid is issued. rst during RESP: the pulse is truncated.
// TESTING
//  1 Reset: rst=1 mid-stream -> all outputs 0, state IDLE; after release, first tie grants req 0.
//  2 Write/read: r0 write addr 8 data 32'hDEADBEEF -> memWrite=1 in T+1 only,
//    resp_valid=2'b01 at T+2, err=0. r0 read addr 8 -> resp_rdata=32'hDEADBEEF, memRead only T+1.
//  3 Contention: both valid continuously, reads -> grants alternate 0,1,0,1 every 3 cycles;
//    resp_valid owner matches the grant.
//  4 Boundary: r1 read addr 60 -> normal access. Addr 61 and 63 -> resp_err=1,
//    resp_rdata=0, memRead/memWrite never asserted.
//  5 Mid-op reset: r0 write addr 0; assert rst during EXEC -> memWrite falls the same cycle,
//    mem[0..3] unchanged, no resp_valid.
//  6 Withdraw: r1 valid for 1 cycle while r0 is owner in EXEC, then dropped -> no grant to r1, rr_ptr unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester sequencer for the 64-byte DataMemory.
// One word access per IDLE/EXEC/RESP pass; out-of-range addresses are rejected.
module dmem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_ADDR = 2**ADDR_W-4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  output logic                memRead,
  output logic                memWrite,
  input  logic [DATA_W-1:0]   mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [ADDR_W-1:0] LP_MAX = ADDR_W'(MAX_ADDR);

  state_t              r_state;
  logic                r_rr;
  logic                r_owner;
  logic                r_we;
  logic                r_legal;

  logic [1:0]          w_grant;
  logic                w_sel;
  logic                w_we;
  logic                w_legal;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // Ties go to r_rr; a lone requester always wins.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE && !rst) begin
      unique case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign w_sel     = w_grant[1];
  assign w_we      = w_sel ? req_we[1] : req_we[0];
  assign w_addr    = w_sel ? req_addr[ADDR_W +: ADDR_W]
                           : req_addr[0 +: ADDR_W];
  assign w_wdata   = w_sel ? req_wdata[DATA_W +: DATA_W]
                           : req_wdata[0 +: DATA_W];
  assign w_legal   = (w_addr <= LP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_legal     <= 1'b0;
      resp_valid  <= 2'b00;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          resp_valid <= 2'b00;
          if (|w_grant) begin
            r_owner     <= w_sel;
            r_we        <= w_we;
            r_legal     <= w_legal;
            r_rr        <= ~w_sel;
            mem_address <= w_addr;
            mem_data_in <= w_wdata;
            memRead     <= w_legal & ~w_we;
            memWrite    <= w_legal & w_we;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Write commits and read data is captured on this edge.
          memRead    <= 1'b0;
          memWrite   <= 1'b0;
          resp_err   <= ~r_legal;
          resp_rdata <= (r_legal && !r_we) ? mem_data_out : '0;
          resp_valid <= r_owner ? 2'b10 : 2'b01;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 2'b00;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table vectors, corner sequences and a
// randomized run against a byte-array reference of the memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        memRead;
  logic        memWrite;
  logic [31:0] mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int m_rr    = 0;
  logic init;

  logic [7:0] pmem [64];
  logic [7:0] ref_mem [64];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .mem_data_out (mem_data_out)
  );

  // Big-endian byte memory: combinational read, write on posedge.
  assign mem_data_out = {pmem[mem_address], pmem[mem_address + 6'd1],
                         pmem[mem_address + 6'd2], pmem[mem_address + 6'd3]};

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) pmem[i] <= 8'h00;
    end else if (memWrite) begin
      pmem[mem_address]        <= mem_data_in[31:24];
      pmem[mem_address + 6'd1] <= mem_data_in[23:16];
      pmem[mem_address + 6'd2] <= mem_data_in[15:8];
      pmem[mem_address + 6'd3] <= mem_data_in[7:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [5:0] a);
    int b;
    b = int'(a);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  task automatic ref_wr(input logic [5:0] a, input logic [31:0] d);
    int b;
    b = int'(a);
    ref_mem[b]   = d[31:24];
    ref_mem[b+1] = d[23:16];
    ref_mem[b+2] = d[15:8];
    ref_mem[b+3] = d[7:0];
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, {30'd0, req_ready}, 32'd0);
    chk({nm, "_rv"}, {30'd0, resp_valid}, 32'd0);
    chk({nm, "_rdata"}, resp_rdata, 32'd0);
    chk({nm, "_err"}, {31'd0, resp_err}, 32'd0);
    chk({nm, "_addr"}, {26'd0, mem_address}, 32'd0);
    chk({nm, "_din"}, mem_data_in, 32'd0);
    chk({nm, "_rdwr"}, {30'd0, memRead, memWrite}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
    #1;
  endtask

  // One arbitration slot, entered and left just after a negedge in IDLE.
  task automatic slot(input logic [1:0] v, input logic [1:0] we,
                      input logic [5:0] a0, input logic [5:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      output logic [31:0] rd, output logic er);
    logic [1:0]  g;
    logic        o, w, lg;
    logic [5:0]  a;
    logic [31:0] d, exp_rd;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    g = (v == 2'b11) ? ((m_rr != 0) ? 2'b10 : 2'b01) : v;
    rd = '0;
    er = 1'b0;
    #1 chk("grant", {30'd0, req_ready}, {30'd0, g});
    if (g == 2'b00) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
    end else begin
      o = g[1];
      w = we[o];
      a = o ? a1 : a0;
      d = o ? d1 : d0;
      lg = (a <= 6'd60);
      m_rr = o ? 0 : 1;
      exp_rd = (lg && !w) ? ref_rd(a) : 32'd0;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("exec_rd", {31'd0, memRead}, {31'd0, lg & ~w});
      chk("exec_wr", {31'd0, memWrite}, {31'd0, lg & w});
      if (lg) chk("exec_addr", {26'd0, mem_address}, {26'd0, a});
      if (lg && w) chk("exec_din", mem_data_in, d);
      chk("exec_ready", {30'd0, req_ready}, 32'd0);
      chk("exec_rv", {30'd0, resp_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("resp_rv", {30'd0, resp_valid}, {30'd0, g});
      chk("resp_err", {31'd0, resp_err}, {31'd0, ~lg});
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_rdwr", {30'd0, memRead, memWrite}, 32'd0);
      chk("resp_ready", {30'd0, req_ready}, 32'd0);
      rd = resp_rdata;
      er = resp_err;
      if (lg && w) ref_wr(a, d);
      @(negedge clk);
      #1 chk("pulse_end", {30'd0, resp_valid}, 32'd0);
    end
  endtask

  typedef struct {
    int          r;
    logic        we;
    logic [5:0]  a;
    logic [31:0] d;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [1:0]  v, we;
    logic [5:0]  a0, a1;

    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    init = 1'b1;
    req_valid = 2'b00;
    req_we = 2'b00;
    req_addr = '0;
    req_wdata = '0;

    tbl[0] = '{0, 1'b1, 6'd8,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{0, 1'b0, 6'd8,  32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b1, 6'd60, 32'h12345678, 1'b0, 32'h0};
    tbl[3] = '{1, 1'b0, 6'd60, 32'h0,        1'b0, 32'h12345678};
    tbl[4] = '{1, 1'b0, 6'd61, 32'h0,        1'b1, 32'h0};
    tbl[5] = '{1, 1'b1, 6'd63, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[6] = '{0, 1'b0, 6'd63, 32'h0,        1'b1, 32'h0};
    tbl[7] = '{0, 1'b1, 6'd5,  32'hA5A50F0F, 1'b0, 32'h0};
    tbl[8] = '{1, 1'b0, 6'd4,  32'h0,        1'b0, 32'h00A5A50F};
    tbl[9] = '{0, 1'b0, 6'd8,  32'h0,        1'b0, 32'h0FADBEEF};

    repeat (2) @(negedge clk);
    #1 chk_zero("por");
    init = 1'b0;
    rst = 1'b0;
    m_rr = 0;
    #1;

    for (int i = 0; i < 10; i++) begin
      v  = (tbl[i].r == 1) ? 2'b10 : 2'b01;
      we = {tbl[i].we, tbl[i].we};
      slot(v, we, tbl[i].a, tbl[i].a, tbl[i].d, tbl[i].d, rd, er);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].err});
    end

    // Contention straight after reset: first tie goes to requester 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      slot(2'b11, 2'b00, 6'd8, 6'd60, 32'h0, 32'h0, rd, er);
      chk($sformatf("cont%0d_rd", k), rd,
          (k % 2 == 0) ? 32'h0FADBEEF : 32'h12345678);
    end

    // Withdraw: r1 pulses valid while r0 owns the memory.
    do_reset();
    req_valid = 2'b01;
    req_we = 2'b00;
    req_addr = {6'd0, 6'd8};
    #1 chk("wd_grant", {30'd0, req_ready}, 32'd1);
    m_rr = 1;
    @(negedge clk);
    req_valid = 2'b10;
    #1 chk("wd_exec_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("wd_resp_rv", {30'd0, resp_valid}, 32'd1);
    @(negedge clk);
    #1 chk("wd_idle_ready", {30'd0, req_ready}, 32'd0);
    slot(2'b11, 2'b00, 6'd8, 6'd4, 32'h0, 32'h0, rd, er);
    chk("wd_tie_rd", rd, 32'h00A5A50F);

    // Reset during EXEC aborts the write.
    req_valid = 2'b01;
    req_we = 2'b01;
    req_addr = {6'd0, 6'd0};
    req_wdata = {32'h0, 32'hCAFEF00D};
    #1 chk("mr_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("mr_exec_wr", {31'd0, memWrite}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_zero("mr_rst");
    @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("mr_no_rv", {30'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    #1;
    slot(2'b01, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, rd, er);
    chk("mr_mem_keep", rd, 32'h00000000);

    for (int k = 0; k < 60; k++) begin
      v  = 2'($urandom_range(0, 3));
      we = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(61, 63))
                                       : 6'($urandom_range(0, 60));
      a1 = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(61, 63))
                                       : 6'($urandom_range(0, 60));
      slot(v, we, a0, a1, $urandom, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
